// File: rtl/axi_lite_master.sv
// axi_lite_master: single-outstanding AXI4-Lite initiator bridging a simple core request port
module axi_lite_master #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_we,
  input  logic [AXI_ADDR_WIDTH-1:0]   req_addr,
  input  logic [AXI_DATA_WIDTH-1:0]   req_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] req_wstrb,
  output logic                        rsp_valid,
  output logic [AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic                        rsp_err,
  output logic [AXI_ADDR_WIDTH-1:0]   M_AXI_awaddr,
  output logic [2:0]                  M_AXI_awprot,
  output logic                        M_AXI_awvalid,
  input  logic                        M_AXI_awready,
  output logic [AXI_DATA_WIDTH-1:0]   M_AXI_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] M_AXI_wstrb,
  output logic                        M_AXI_wvalid,
  input  logic                        M_AXI_wready,
  input  logic [1:0]                  M_AXI_bresp,
  input  logic                        M_AXI_bvalid,
  output logic                        M_AXI_bready,
  output logic [AXI_ADDR_WIDTH-1:0]   M_AXI_araddr,
  output logic [2:0]                  M_AXI_arprot,
  output logic                        M_AXI_arvalid,
  input  logic                        M_AXI_arready,
  input  logic [AXI_DATA_WIDTH-1:0]   M_AXI_rdata,
  input  logic [1:0]                  M_AXI_rresp,
  input  logic                        M_AXI_rvalid,
  output logic                        M_AXI_rready
);
  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_e;
  state_e                        state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [AXI_DATA_WIDTH-1:0]     wdata_q, wdata_d, rdata_q, rdata_d;
  logic [AXI_DATA_WIDTH/8-1:0]   wstrb_q, wstrb_d;
  logic                          awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
  logic                          err_q, err_d;
  logic                          misaligned;
  logic                          unused_resp;
  assign misaligned  = |req_addr[1:0];
  assign unused_resp = ^{M_AXI_bresp[0], M_AXI_rresp[0]};
  assign req_ready     = (state_q == IDLE) && !areset;
  assign rsp_valid     = state_q == RESP;
  assign rsp_rdata     = rdata_q;
  assign rsp_err       = err_q;
  assign M_AXI_awaddr  = addr_q;
  assign M_AXI_araddr  = addr_q;
  assign M_AXI_awprot  = 3'b000;
  assign M_AXI_arprot  = 3'b000;
  assign M_AXI_wdata   = wdata_q;
  assign M_AXI_wstrb   = wstrb_q;
  assign M_AXI_awvalid = awvalid_q;
  assign M_AXI_wvalid  = wvalid_q;
  assign M_AXI_arvalid = arvalid_q;
  assign M_AXI_bready  = state_q == WRITE;
  assign M_AXI_rready  = state_q == READ;
  // next-state: accept request, drop each valid after its own handshake, capture response
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    case (state_q)
      IDLE: if (req_valid && req_ready) begin
        addr_d    = req_addr;
        wdata_d   = req_wdata;
        wstrb_d   = req_wstrb;
        rdata_d   = '0;
        err_d     = misaligned;
        awvalid_d = !misaligned && req_we;
        wvalid_d  = !misaligned && req_we;
        arvalid_d = !misaligned && !req_we;
        state_d   = misaligned ? RESP : (req_we ? WRITE : READ);
      end
      WRITE: begin
        awvalid_d = awvalid_q && !M_AXI_awready;
        wvalid_d  = wvalid_q && !M_AXI_wready;
        if (M_AXI_bvalid) begin
          err_d   = M_AXI_bresp[1];
          rdata_d = '0;
          state_d = RESP;
        end
      end
      READ: begin
        arvalid_d = arvalid_q && !M_AXI_arready;
        if (M_AXI_rvalid) begin
          err_d   = M_AXI_rresp[1];
          rdata_d = M_AXI_rresp[1] ? '0 : M_AXI_rdata;
          state_d = RESP;
        end
      end
      RESP: state_d = IDLE;
    endcase
  end
  // state and datapath registers, reset aborts any transaction in flight
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
    end
  end
endmodule
